// File: rtl/render_scheduler.sv
// render_scheduler: per-frame erase/draw sequencer feeding a req/ack box-drawing engine.
// Define RENDER_SKIP_STATIC_EN to skip objects unchanged since the previous frame.
module render_scheduler #(
  parameter int NUM_OBJ = 5,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic                   CLOCK_50,
  input  logic                   resetn,
  input  logic                   frame,
  input  logic [15*NUM_OBJ-1:0]  obj_pos,
  input  logic [3*NUM_OBJ-1:0]   obj_colour,
  input  logic [NUM_OBJ-1:0]     obj_visible,
  input  logic                   draw_ack,
  output logic                   draw_req,
  output logic [14:0]            plot_xy,
  output logic [2:0]             colour,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun
);
  localparam int IW = NUM_OBJ > 1 ? $clog2(NUM_OBJ) : 1;
  typedef enum logic [2:0] {IDLE, SNAP, ERASE, ERASE_WAIT, DRAW, DRAW_WAIT, NEXT, DONE} state_t;
  state_t             state_q;
  logic [IW-1:0]      idx_q;
  logic [14:0]        shadow_pos_q [NUM_OBJ];
  logic [2:0]         shadow_colour_q [NUM_OBJ];
  logic [NUM_OBJ-1:0] shadow_vis_q;
  logic [14:0]        prev_pos_q [NUM_OBJ];
  logic [NUM_OBJ-1:0] prev_vis_q;
  logic               draw_req_q, busy_q, frame_done_q, overrun_q;
  logic [14:0]        plot_xy_q;
  logic [2:0]         colour_q;
  logic               skip;
`ifdef RENDER_SKIP_STATIC_EN
  logic [2:0]         prev_colour_q [NUM_OBJ];
  assign skip = prev_vis_q[idx_q] && shadow_vis_q[idx_q] && shadow_pos_q[idx_q] == prev_pos_q[idx_q]
                && shadow_colour_q[idx_q] == prev_colour_q[idx_q];
`else
  assign skip = 1'b0;
`endif
  assign draw_req   = draw_req_q;
  assign plot_xy    = plot_xy_q;
  assign colour     = colour_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      draw_req_q   <= 1'b0;
      plot_xy_q    <= '0;
      colour_q     <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      shadow_vis_q <= '0;
      prev_vis_q   <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        shadow_pos_q[i]    <= '0;
        shadow_colour_q[i] <= '0;
        prev_pos_q[i]      <= '0;
`ifdef RENDER_SKIP_STATIC_EN
        prev_colour_q[i]   <= '0;
`endif
      end
    end else begin
      // ticks outside IDLE are dropped, only remembered here
      if (frame && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: if (frame) begin
          state_q <= SNAP;
          busy_q  <= 1'b1;
        end
        SNAP: begin
          for (int i = 0; i < NUM_OBJ; i++) begin
            shadow_pos_q[i]    <= obj_pos[15*i +: 15];
            shadow_colour_q[i] <= obj_colour[3*i +: 3];
          end
          shadow_vis_q <= obj_visible;
          idx_q        <= '0;
          state_q      <= ERASE;
        end
        ERASE: if (skip) state_q <= NEXT;
          else if (prev_vis_q[idx_q]) begin
            draw_req_q <= 1'b1;
            plot_xy_q  <= prev_pos_q[idx_q];
            colour_q   <= BG_COLOUR;
            state_q    <= ERASE_WAIT;
          end else state_q <= DRAW;
        ERASE_WAIT: if (draw_ack) begin
          draw_req_q <= 1'b0;
          state_q    <= DRAW;
        end
        DRAW: if (shadow_vis_q[idx_q]) begin
            draw_req_q <= 1'b1;
            plot_xy_q  <= shadow_pos_q[idx_q];
            colour_q   <= shadow_colour_q[idx_q];
            state_q    <= DRAW_WAIT;
          end else state_q <= NEXT;
        DRAW_WAIT: if (draw_ack) begin
          draw_req_q <= 1'b0;
          state_q    <= NEXT;
        end
        NEXT: begin
          prev_pos_q[idx_q]    <= shadow_pos_q[idx_q];
          prev_vis_q[idx_q]    <= shadow_vis_q[idx_q];
`ifdef RENDER_SKIP_STATIC_EN
          prev_colour_q[idx_q] <= shadow_colour_q[idx_q];
`endif
          if (idx_q == IW'(NUM_OBJ - 1)) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= ERASE;
          end
        end
        DONE: begin
          frame_done_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_render_scheduler.sv
// tb_render_scheduler: randomized frames checked against a request-list model of the scheduler.
module tb_render_scheduler;
  localparam int N = 5;
`ifdef RENDER_SKIP_STATIC_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif
  logic clk = 0, resetn = 0, frame = 0, draw_ack = 0;
  logic [15*N-1:0] obj_pos = '0;
  logic [3*N-1:0] obj_colour = '0;
  logic [N-1:0] obj_visible = '0;
  logic draw_req, busy, frame_done, overrun;
  logic [14:0] plot_xy;
  logic [2:0] colour;
  int tests = 0, fails = 0;
  logic [14:0] m_pos [N];
  logic [2:0] m_col [N];
  logic m_vis [N];
  logic exp_ovr = 0;
  logic [17:0] exp_q [$];

  always #10 clk = ~clk;

  render_scheduler #(.NUM_OBJ(N), .BG_COLOUR(3'b000)) dut (
    .CLOCK_50(clk), .resetn(resetn), .frame(frame), .obj_pos(obj_pos),
    .obj_colour(obj_colour), .obj_visible(obj_visible), .draw_ack(draw_ack),
    .draw_req(draw_req), .plot_xy(plot_xy), .colour(colour), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      m_pos[i] = '0;
      m_col[i] = '0;
      m_vis[i] = 1'b0;
    end
    exp_ovr = 1'b0;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < N; i++) begin
      obj_pos[15*i +: 15]  = 15'($urandom);
      obj_colour[3*i +: 3] = 3'($urandom);
      obj_visible[i]       = $urandom_range(0, 3) != 0;
    end
  endtask

  // expected request list for a frame snapshotting the current inputs
  task automatic build_expected();
    logic [14:0] p;
    logic [2:0] c;
    logic v;
    bit skip;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      p = obj_pos[15*i +: 15];
      c = obj_colour[3*i +: 3];
      v = obj_visible[i];
      skip = SKIP_EN && m_vis[i] && v && p == m_pos[i] && c == m_col[i];
      if (!skip && m_vis[i]) exp_q.push_back({m_pos[i], 3'b000});
      if (!skip && v) exp_q.push_back({p, c});
      m_pos[i] = p;
      m_col[i] = c;
      m_vis[i] = v;
    end
  endtask

  task automatic run_frame(input bit inj_ovr, input bit at_done, input bit scramble);
    bit done = 0, prev_req = 0, injected = 0;
    int wait_c = 0, nreq = 0, exp_n;
    logic [17:0] cur = '0, e;
    build_expected();
    exp_n = exp_q.size();
    frame = 1;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      frame = 0;
      draw_ack = 0;
      if (scramble && cyc == 3) randomize_inputs();
      if (draw_req && !prev_req) begin
        nreq++;
        cur = {plot_xy, colour};
        if (exp_q.size() == 0) check("extra_req", nreq, exp_n);
        else begin
          e = exp_q.pop_front();
          check("req_xy", plot_xy, e[17:3]);
          check("req_colour", colour, e[2:0]);
        end
        check("busy_in_req", busy, 1);
        wait_c = $urandom_range(0, 3);
      end else if (draw_req) check("req_stable", {plot_xy, colour}, cur);
      prev_req = draw_req;
      if (draw_req) begin
        if (wait_c == 0) draw_ack = 1;
        else wait_c--;
      end else if ($urandom_range(0, 7) == 0) draw_ack = 1;
      if (inj_ovr && !injected && draw_req && cyc >= 4) begin
        frame = 1;
        injected = 1;
        exp_ovr = 1;
      end
      if (frame_done) begin
        done = 1;
        check("busy_at_done", busy, 0);
        check("req_count", nreq, exp_n);
        if (at_done) begin
          frame = 1;
          exp_ovr = 1;
        end
      end
    end
    if (!done) check("frame_timeout", 0, 1);
    @(negedge clk);
    frame = 0;
    draw_ack = 0;
    check("done_pulse", frame_done, 0);
    check("overrun", overrun, exp_ovr);
  endtask

  task automatic reset_mid_request();
    bit seen = 0;
    build_expected();
    frame = 1;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      frame = 0;
      draw_ack = 0;
      if (draw_req) seen = 1;
    end
    check("rst_req_seen", seen, 1);
    check("rst_first_xy", plot_xy, exp_q[0][17:3]);
    check("rst_first_colour", colour, exp_q[0][2:0]);
    resetn = 0;
    #1;
    check("rst_req_drop", draw_req, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    clear_model();
    @(negedge clk);
    resetn = 1;
  endtask

  initial begin
    clear_model();
    randomize_inputs();
    repeat (3) @(negedge clk);
    check("rst_draw_req", draw_req, 0);
    check("rst_plot_xy", plot_xy, 0);
    check("rst_colour", colour, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    resetn = 1;
    @(negedge clk);
    obj_visible = '1;
    obj_pos[14:0] = {8'd100, 7'd20};
    obj_colour[2:0] = 3'b100;
    run_frame(0, 0, 0);
    obj_pos[14:0] = {8'd101, 7'd20};
    obj_visible[2] = 1'b0;
    run_frame(1, 0, 0);
    run_frame(0, 1, 0);
    run_frame(0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      randomize_inputs();
      run_frame($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end
    randomize_inputs();
    obj_visible = '1;
    run_frame(0, 0, 0);
    randomize_inputs();
    obj_visible = '1;
    reset_mid_request();
    run_frame(0, 0, 0);
    randomize_inputs();
    obj_visible = '1;
    run_frame(0, 0, 0);
    run_frame(0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
